wb_dac_multi: RTL and testbench
===============================

// Module: wb_dac_multi
// PURPOSE
//  Wishbone-attached N-channel audio sigma-delta DAC, successor to the stereo DAC path.
//  Host writes interleaved PCM samples into a shared FIFO. A frame timer pops one N_CH-sample frame per sample period.
//  Each channel then drives a 1st-order sigma-delta bitstream pin.
//  Adds CSR-controlled enable/flush, underrun/overflow sticky flags, a low-water IRQ and signed/unsigned sample modes.
// PARAMETERS
//  SYS_FREQ_HZ    150_000_000  system clock frequency
//  DATA_WIDTH     16           wishbone data width; also the sample width
//  ADDR_WIDTH     12           wishbone address width; wb_adr_i[ADDR_WIDTH-1] selects CSR (1) or FIFO (0)
//  N_CH           2            output channels, 1..8
//  FIFO_AW        9            FIFO depth = 2**FIFO_AW samples; must be >= log2(2*N_CH)
//  MOD_FREQ_HZ    4_000_000    modulator update rate; MOD_DIV = SYS_FREQ_HZ/MOD_FREQ_HZ (>=2)
// PORTS
//  clk          in   1           system clock
//  resetn       in   1           asynchronous active-low reset
//  wb_stb_i     in   1           wishbone strobe
//  wb_cyc_i     in   1           wishbone cycle
//  wb_we_i      in   1           wishbone write enable
//  wb_sel_i     in   2           byte selects (ignored, full-word access only)
//  wb_adr_i     in   ADDR_WIDTH  word address
//  wb_dat_i     in   DATA_WIDTH  write data
//  wb_dat_o     out  DATA_WIDTH  read data, registered
//  wb_ack_o     out  1           single-cycle acknowledge
//  dac_out      out  N_CH        sigma-delta bitstreams, bit k = channel k
//  irq_lowater  out  1           level, high while enabled and fifo_level < LOWATER
// BEHAVIOUR
//  Reset: all outputs 0. FIFO empty, CSRs at their reset values, modulator accumulators = 2**(DATA_WIDTH-1).
//  WB: any stb&cyc with ack low gives ack high for exactly 1 cycle on the next clock. No wait states; back-to-back cycles give ack every 2nd clock.
//  FIFO write (adr MSB=0, any offset): push wb_dat_i.
//   - FIFO full: data dropped, ack still given, OVF sticky set.
//   - Push and pop in the same cycle: both happen; level unchanged.
//  CSR map, adr[2:0]:
//   0 CTRL   rw  b0 EN (reset 0); b1 FLUSH (write 1 = one-cycle pulse, reads 0); b2 SIGNED (reset 1)
//   1 STATUS r/w1c  b0 EMPTY, b1 FULL, b2 UNDERRUN sticky, b3 OVF sticky; writing 1 clears b2/b3
//   2 FRAME_DIV rw  modulator ticks per sample period minus 1; reset 90 (44.1 kHz at 4 MHz); value <N_CH+1 clamps to N_CH+1
//   3 LEVEL  r  FIFO occupancy, 0..2**FIFO_AW, zero-extended
//   4 LOWATER rw  IRQ threshold; reset 2**(FIFO_AW-1)
//   5-7 read 0, writes ignored
//  Modulator tick: free-running divider, 1-cycle tick every MOD_DIV clocks; frame counter advances on ticks.
//   Frame boundary = tick with counter == FRAME_DIV, after which the counter wraps to 0.
//  Frame FSM states: IDLE, FETCH, READY.
//   - IDLE: EN=0. Shadow and active regs held at midscale.
//   - IDLE->FETCH when EN=1 and level >= N_CH.
//   - FETCH: pop one sample per clock into shadow[ch], ch = 0..N_CH-1, exactly N_CH consecutive clocks. Then go to READY.
//   - READY, at a frame boundary: active <= shadow. Then FETCH if level >= N_CH, else stay READY and set UNDERRUN.
//   - READY, frame boundary with no fresh shadow (underrun): active <= midscale (silence, not last sample).
//   - Sample order: a frame is always N_CH samples. Partial frames are never popped, so channel alignment is preserved.
//  Sigma-delta per channel, on each tick:
//   - u = SIGNED ? {~s[MSB], s[MSB-1:0]} : s
//   - acc (DATA_WIDTH+1 bits) <= {1'b0, acc[DATA_WIDTH-1:0]} + u
//   - dac_out[k] <= acc[DATA_WIDTH] (registered; 1 clock after tick)
//  EN 1->0: FSM to IDLE at once, active=midscale, FIFO contents kept.
//  FLUSH: pointers/level to 0 next clock. FSM returns to IDLE and EN is kept, so FETCH resumes when data is refilled.
//   FLUSH wins over a same-cycle push.
//  Pointers are FIFO_AW+1 bits and wrap naturally. Full = ptr MSBs differ and the rest are equal.
//  Async reset mid-frame: everything returns to reset values immediately; no partial-frame state survives.
// TESTING
//  1 Reset, read CSR0..4 -> 0x0004,0x0001,90,0,256 (FIFO_AW=9). dac_out=0, wb_ack_o=0.
//  2 N_CH=2, FRAME_DIV=9, EN=1, push 0x7FFF,0x8000 (signed) -> ch0 density ~1.0 and ch1 ~0.0 within 20 ticks after first frame boundary.
//  3 Push 3 samples, N_CH=2 -> one frame played. Next boundary sets UNDERRUN, outputs midscale (~50% density), LEVEL=1 held.
//  4 Push 2**FIFO_AW+1 with EN=0 -> FULL=1, OVF=1, LEVEL=512. Every write acked; write 1 to STATUS b3 -> OVF=0.
//  5 FLUSH same cycle as a push at LEVEL=5 -> LEVEL=0 next read, EMPTY=1.
//  6 LOWATER=4, level drains 5->3 during playback -> irq_lowater rises the cycle level becomes 3. EN=0 -> irq low.

Source files
------------

// File: rtl/wb_dac_multi.sv
// ---------------------------------------------------------------------------
// wb_dac_multi
//   Wishbone-attached N-channel sigma-delta audio DAC. The host writes
//   interleaved PCM samples into a shared FIFO; a frame timer moves one
//   N_CH-sample frame per sample period into the active registers, and each
//   channel drives a 1st-order sigma-delta bitstream.
//
// Ports
//   clk, resetn          system clock, asynchronous active-low reset
//   wb_stb_i, wb_cyc_i   wishbone strobe / cycle
//   wb_we_i              wishbone write enable
//   wb_sel_i             byte selects (full-word access only, ignored)
//   wb_adr_i             word address; MSB=1 selects CSRs, MSB=0 the FIFO
//   wb_dat_i / wb_dat_o  write data / registered read data
//   wb_ack_o             single-cycle acknowledge
//   dac_out              bitstreams, bit k = channel k
//   irq_lowater          high while EN=1 and FIFO level < LOWATER
// ---------------------------------------------------------------------------
module wb_dac_multi #(
  parameter int SYS_FREQ_HZ = 150_000_000,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 12,
  parameter int N_CH        = 2,
  parameter int FIFO_AW     = 9,
  parameter int MOD_FREQ_HZ = 4_000_000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_we_i,
  input  logic [1:0]            wb_sel_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic [N_CH-1:0]       dac_out,
  output logic                  irq_lowater
);

  localparam int MOD_DIV = SYS_FREQ_HZ / MOD_FREQ_HZ;
  localparam int DIV_W   = (MOD_DIV > 1) ? $clog2(MOD_DIV) : 1;
  localparam int LVL_W   = FIFO_AW + 1;
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int DEPTH   = 2 ** FIFO_AW;

  localparam logic [DATA_WIDTH-1:0] MIDSCALE    = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] FRAME_MIN   = DATA_WIDTH'(N_CH + 1);
  localparam logic [DATA_WIDTH-1:0] FRAME_RST   = DATA_WIDTH'(90);
  localparam logic [DATA_WIDTH-1:0] LOWATER_RST = DATA_WIDTH'(2 ** (FIFO_AW - 1));

  localparam logic [2:0] A_CTRL      = 3'd0;
  localparam logic [2:0] A_STATUS    = 3'd1;
  localparam logic [2:0] A_FRAME_DIV = 3'd2;
  localparam logic [2:0] A_LEVEL     = 3'd3;
  localparam logic [2:0] A_LOWATER   = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_READY} state_t;

  // Shadow/active registers hold offset-binary values, so midscale is the
  // same constant in both sample modes.
  function automatic logic [DATA_WIDTH-1:0] to_offset(input logic [DATA_WIDTH-1:0] s,
                                                      input logic is_signed);
    return is_signed ? {~s[DATA_WIDTH-1], s[DATA_WIDTH-2:0]} : s;
  endfunction

  // Bus / CSR state
  logic                  r_ack;
  logic [DATA_WIDTH-1:0] r_dat;
  logic                  r_en, r_signed, r_ovf, r_und;
  logic [DATA_WIDTH-1:0] r_frame_div, r_lowater;
  // FIFO
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [LVL_W-1:0]      r_wr_ptr, r_rd_ptr;
  // Timing
  logic [DIV_W-1:0]      r_div;
  logic                  r_tick;
  logic [DATA_WIDTH-1:0] r_frame_cnt;
  // Frame FSM and modulator
  state_t                r_state;
  logic [CH_W-1:0]       r_ch;
  logic                  r_fresh;
  logic [DATA_WIDTH-1:0] r_shadow [N_CH];
  logic [DATA_WIDTH-1:0] r_active [N_CH];
  logic [DATA_WIDTH:0]   r_acc    [N_CH];
  logic [N_CH-1:0]       r_dac;

  logic                  w_access, w_is_csr, w_fifo_wr, w_csr_wr, w_flush;
  logic                  w_push, w_pop, w_full, w_empty, w_boundary, w_unused;
  logic [2:0]            w_sel;
  logic [LVL_W-1:0]      w_level;
  logic [DATA_WIDTH-1:0] w_csr_rdata;

  // A new access is accepted only while ack is low, which yields the
  // ack-every-second-clock behaviour for back-to-back strobes.
  assign w_access  = wb_stb_i & wb_cyc_i & ~r_ack;
  assign w_is_csr  = wb_adr_i[ADDR_WIDTH-1];
  assign w_sel     = wb_adr_i[2:0];
  assign w_fifo_wr = w_access & wb_we_i & ~w_is_csr;
  assign w_csr_wr  = w_access & wb_we_i & w_is_csr;
  assign w_flush   = w_csr_wr && (w_sel == A_CTRL) && wb_dat_i[1];

  assign w_level   = r_wr_ptr - r_rd_ptr;
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                     (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
  assign w_push    = w_fifo_wr & ~w_full & ~w_flush;
  assign w_pop     = (r_state == S_FETCH) & r_en & ~w_flush;
  assign w_boundary = r_tick && (r_frame_cnt >= r_frame_div);
  assign w_unused  = ^{wb_sel_i, wb_adr_i[ADDR_WIDTH-2:3]};

  assign wb_ack_o    = r_ack;
  assign wb_dat_o    = r_dat;
  assign dac_out     = r_dac;
  assign irq_lowater = r_en && (DATA_WIDTH'(w_level) < r_lowater);

  // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_csr_rdata = '0;
    case (w_sel)
      A_CTRL:      w_csr_rdata = DATA_WIDTH'({r_signed, 1'b0, r_en});
      A_STATUS:    w_csr_rdata = DATA_WIDTH'({r_ovf, r_und, w_full, w_empty});
      A_FRAME_DIV: w_csr_rdata = r_frame_div;
      A_LEVEL:     w_csr_rdata = DATA_WIDTH'(w_level);
      A_LOWATER:   w_csr_rdata = r_lowater;
      default:     w_csr_rdata = '0;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_access;
      if (w_access) r_dat <= (w_is_csr && !wb_we_i) ? w_csr_rdata : '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_en        <= 1'b0;
      r_signed    <= 1'b1;
      r_ovf       <= 1'b0;
      r_frame_div <= FRAME_RST;
      r_lowater   <= LOWATER_RST;
    end else begin
      if (w_csr_wr) begin
        case (w_sel)
          A_CTRL:      begin r_en <= wb_dat_i[0]; r_signed <= wb_dat_i[2]; end
          A_STATUS:    if (wb_dat_i[3]) r_ovf <= 1'b0;
          A_FRAME_DIV: r_frame_div <= (wb_dat_i < FRAME_MIN) ? FRAME_MIN : wb_dat_i;
          A_LOWATER:   r_lowater <= wb_dat_i;
          default:     ;
        endcase
      end
      if (w_fifo_wr && w_full) r_ovf <= 1'b1;
    end
  end

  // NOTE: the sample RAM has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= wb_dat_i;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LVL_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LVL_W'(1);
    end
  end

  // Modulator tick and frame counter. The >= compare keeps the counter
  // bounded when FRAME_DIV is lowered below the current count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div       <= '0;
      r_tick      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_div  <= (r_div == DIV_W'(MOD_DIV - 1)) ? '0 : r_div + DIV_W'(1);
      r_tick <= (r_div == DIV_W'(MOD_DIV - 1));
      if (r_tick) r_frame_cnt <= (r_frame_cnt >= r_frame_div) ? '0 : r_frame_cnt + DATA_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_fresh <= 1'b0;
      r_und   <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        r_shadow[k] <= MIDSCALE;
        r_active[k] <= MIDSCALE;
      end
    end else begin
      if (w_csr_wr && (w_sel == A_STATUS) && wb_dat_i[2]) r_und <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ch    <= '0;
          r_fresh <= 1'b0;
          for (int k = 0; k < N_CH; k++) begin
            r_shadow[k] <= MIDSCALE;
            r_active[k] <= MIDSCALE;
          end
          // Only whole frames are fetched, keeping channels aligned.
          if (w_level >= LVL_W'(N_CH)) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_shadow[r_ch] <= to_offset(r_mem[r_rd_ptr[FIFO_AW-1:0]], r_signed);
          if (r_ch == CH_W'(N_CH - 1)) begin
            r_ch    <= '0;
            r_fresh <= 1'b1;
            r_state <= S_READY;
          end else begin
            r_ch <= r_ch + CH_W'(1);
          end
        end
        S_READY: begin
          if (w_boundary) begin
            // A stale shadow plays silence rather than repeating the last frame.
            for (int k = 0; k < N_CH; k++) r_active[k] <= r_fresh ? r_shadow[k] : MIDSCALE;
            r_fresh <= 1'b0;
            if (w_level >= LVL_W'(N_CH)) r_state <= S_FETCH;
            else                         r_und   <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Disable or flush aborts any frame in progress.
      if (!r_en || w_flush) begin
        r_state <= S_IDLE;
        r_ch    <= '0;
        for (int k = 0; k < N_CH; k++) r_active[k] <= MIDSCALE;
      end
    end
  end

  // First-order sigma-delta: the carry out of the accumulator is the bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dac <= '0;
      for (int k = 0; k < N_CH; k++) r_acc[k] <= {1'b0, MIDSCALE};
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (r_tick) r_acc[k] <= {1'b0, r_acc[k][DATA_WIDTH-1:0]} + {1'b0, r_active[k]};
        r_dac[k] <= r_acc[k][DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_wb_dac_multi.sv
// ---------------------------------------------------------------------------
// tb_wb_dac_multi
//   Directed bench for wb_dac_multi (N_CH=2, FIFO_AW=9, 16-bit data).
//   CSR reset values and read/write behaviour come from a vector table;
//   playback, underrun, overflow, flush, low-water IRQ and async reset are
//   exercised with short hand-written sequences.
// ---------------------------------------------------------------------------
module tb_wb_dac_multi;

  localparam int DW  = 16;
  localparam int AW  = 12;
  localparam int NCH = 2;
  localparam int FAW = 9;
  localparam logic [AW-1:0] CSR_BASE = 12'h800;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            wb_stb_i = 1'b0;
  logic            wb_cyc_i = 1'b0;
  logic            wb_we_i = 1'b0;
  logic [1:0]      wb_sel_i = 2'b11;
  logic [AW-1:0]   wb_adr_i = '0;
  logic [DW-1:0]   wb_dat_i = '0;
  logic [DW-1:0]   wb_dat_o;
  logic            wb_ack_o;
  logic [NCH-1:0]  dac_out;
  logic            irq_lowater;

  wb_dac_multi #(
    .SYS_FREQ_HZ(150_000_000),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .N_CH       (NCH),
    .FIFO_AW    (FAW),
    .MOD_FREQ_HZ(4_000_000)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .wb_stb_i   (wb_stb_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_we_i    (wb_we_i),
    .wb_sel_i   (wb_sel_i),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .dac_out    (dac_out),
    .irq_lowater(irq_lowater)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_errs = 0;

  typedef struct {
    logic          we;
    logic [2:0]    rsel;
    logic [DW-1:0] wdat;
    logic [DW-1:0] exp;
    string         name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic add_vec(input logic we, input logic [2:0] rsel, input logic [DW-1:0] wdat,
                         input logic [DW-1:0] exp, input string name);
    vec_t v;
    v.we = we; v.rsel = rsel; v.wdat = wdat; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  // One wishbone transfer; ack must arrive on the first edge and last one cycle.
  task automatic wb_xfer(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] wdat,
                         output logic [DW-1:0] rdat, output logic acked);
    int waited;
    @(negedge clk);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = wdat;
    waited = 0;
    acked  = 1'b0;
    while (!acked && waited < 4) begin
      @(posedge clk); #1;
      waited++;
      if (wb_ack_o === 1'b1) acked = 1'b1;
    end
    rdat = wb_dat_o;
    if (!acked || waited != 1) ack_errs++;
    @(negedge clk);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk); #1;
    if (wb_ack_o !== 1'b0) ack_errs++;
  endtask

  task automatic csr_wr(input logic [2:0] rsel, input logic [DW-1:0] dat);
    logic [DW-1:0] d;
    logic a;
    wb_xfer(1'b1, CSR_BASE | AW'(rsel), dat, d, a);
  endtask

  task automatic csr_rd(input logic [2:0] rsel, output logic [DW-1:0] dat);
    logic a;
    wb_xfer(1'b0, CSR_BASE | AW'(rsel), '0, dat, a);
  endtask

  task automatic fifo_push(input logic [DW-1:0] dat, output logic acked);
    logic [DW-1:0] d;
    wb_xfer(1'b1, AW'(0), dat, d, acked);
  endtask

  task automatic do_reset();
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic wait_dac(input logic [NCH-1:0] pat, input int budget, output logic found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (dac_out === pat) found = 1'b1;
    end
  endtask

  task automatic count_high(input int cycles, output int n0, output int n1);
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (dac_out[0] === 1'b1) n0++;
      if (dac_out[1] === 1'b1) n1++;
    end
  endtask

  // Full-scale on ch0 and zero on ch1 must give constant 1 / constant 0.
  task automatic run_density(input logic sgn, input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                             input string tag);
    logic a, found;
    int n0, n1;
    do_reset();
    csr_wr(3'd2, 16'd9);
    for (int f = 0; f < 4; f++) begin
      fifo_push(s0, a);
      fifo_push(s1, a);
    end
    csr_wr(3'd0, sgn ? 16'h0005 : 16'h0001);
    wait_dac(2'b01, 2500, found);
    check({tag, "_play_start"}, 32'(found), 32'd1);
    count_high(300, n0, n1);
    check({tag, "_ch0_density"}, 32'(n0), 32'd300);
    check({tag, "_ch1_density"}, 32'(n1), 32'd0);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] rd;
    logic a, found;
    logic [5:0] pat;
    int n0, n1, acks;

    // ---------------- Reset state and CSR table ----------------
    do_reset();
    @(negedge clk);
    check("rst_dac_out", 32'(dac_out), 32'd0);
    check("rst_ack", 32'(wb_ack_o), 32'd0);
    check("rst_irq", 32'(irq_lowater), 32'd0);

    add_vec(1'b0, 3'd0, 16'h0000, 16'h0004, "rst_ctrl");
    add_vec(1'b0, 3'd1, 16'h0000, 16'h0001, "rst_status");
    add_vec(1'b0, 3'd2, 16'h0000, 16'd90,   "rst_frame_div");
    add_vec(1'b0, 3'd3, 16'h0000, 16'h0000, "rst_level");
    add_vec(1'b0, 3'd4, 16'h0000, 16'd256,  "rst_lowater");
    add_vec(1'b0, 3'd5, 16'h0000, 16'h0000, "rd_reg5");
    add_vec(1'b0, 3'd7, 16'h0000, 16'h0000, "rd_reg7");
    add_vec(1'b1, 3'd2, 16'd1,    16'h0000, "");
    add_vec(1'b0, 3'd2, 16'h0000, 16'd3,    "frame_div_clamp");
    add_vec(1'b1, 3'd2, 16'd50,   16'h0000, "");
    add_vec(1'b0, 3'd2, 16'h0000, 16'd50,   "frame_div_rw");
    add_vec(1'b1, 3'd4, 16'd7,    16'h0000, "");
    add_vec(1'b0, 3'd4, 16'h0000, 16'd7,    "lowater_rw");
    add_vec(1'b1, 3'd6, 16'hFFFF, 16'h0000, "");
    add_vec(1'b0, 3'd6, 16'h0000, 16'h0000, "reg6_ignored");
    add_vec(1'b1, 3'd1, 16'h000C, 16'h0000, "");
    add_vec(1'b0, 3'd1, 16'h0000, 16'h0001, "status_w1c_idle");
    add_vec(1'b1, 3'd0, 16'h0000, 16'h0000, "");
    add_vec(1'b0, 3'd0, 16'h0000, 16'h0000, "ctrl_unsigned");
    add_vec(1'b1, 3'd0, 16'h0006, 16'h0000, "");
    add_vec(1'b0, 3'd0, 16'h0000, 16'h0004, "ctrl_flush_reads0");

    foreach (vecs[i]) begin
      if (vecs[i].we) begin
        csr_wr(vecs[i].rsel, vecs[i].wdat);
      end else begin
        csr_rd(vecs[i].rsel, rd);
        check(vecs[i].name, 32'(rd), 32'(vecs[i].exp));
      end
    end

    // FIFO-space reads return zero.
    wb_xfer(1'b0, AW'(5), '0, rd, a);
    check("fifo_space_read", 32'(rd), 32'd0);

    // Back-to-back strobe: ack on every second clock.
    @(negedge clk);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = CSR_BASE | AW'(3);
    pat = '0;
    repeat (6) begin
      @(posedge clk); #1;
      pat = {pat[4:0], wb_ack_o};
    end
    @(negedge clk);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    @(posedge clk); #1;
    check("b2b_ack_pattern", 32'(pat), 32'(6'b101010));

    // ---------------- Playback density, signed and unsigned ----------------
    run_density(1'b1, 16'h7FFF, 16'h8000, "signed");
    run_density(1'b0, 16'hFFFF, 16'h0000, "unsigned");

    // ---------------- Underrun: 3 samples, one frame then silence ----------------
    do_reset();
    csr_wr(3'd2, 16'd9);
    fifo_push(16'h7FFF, a);
    fifo_push(16'h8000, a);
    fifo_push(16'h1234, a);
    csr_wr(3'd0, 16'h0005);
    wait_dac(2'b01, 2500, found);
    check("underrun_frame_played", 32'(found), 32'd1);
    repeat (800) @(negedge clk);
    csr_rd(3'd1, rd);
    check("underrun_status", 32'(rd), 32'h0004);
    csr_rd(3'd3, rd);
    check("underrun_level_held", 32'(rd), 32'd1);
    count_high(370, n0, n1);
    check_range("underrun_ch0_midscale", n0, 140, 230);
    check_range("underrun_ch1_midscale", n1, 140, 230);

    // ---------------- Async reset mid-playback ----------------
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (dac_out[0] === 1'b1) found = 1'b1;
    end
    check("arst_dac_high_before", 32'(found), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("arst_dac_out", 32'(dac_out), 32'd0);
    check("arst_irq", 32'(irq_lowater), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    csr_rd(3'd1, rd);
    check("arst_status", 32'(rd), 32'h0001);
    csr_rd(3'd3, rd);
    check("arst_level", 32'(rd), 32'd0);
    csr_rd(3'd0, rd);
    check("arst_ctrl", 32'(rd), 32'h0004);

    // ---------------- Overflow: 2**FIFO_AW+1 writes with EN=0 ----------------
    do_reset();
    acks = 0;
    for (int i = 0; i < 513; i++) begin
      fifo_push(16'(i), a);
      if (a) acks++;
    end
    check("ovf_all_acked", 32'(acks), 32'd513);
    csr_rd(3'd1, rd);
    check("ovf_status", 32'(rd), 32'h000A);
    csr_rd(3'd3, rd);
    check("ovf_level", 32'(rd), 32'd512);
    csr_wr(3'd1, 16'h0008);
    csr_rd(3'd1, rd);
    check("ovf_cleared", 32'(rd), 32'h0002);

    // ---------------- Flush right behind a push ----------------
    do_reset();
    for (int i = 0; i < 5; i++) fifo_push(16'h1111 * 16'(i + 1), a);
    csr_rd(3'd3, rd);
    check("flush_level_before", 32'(rd), 32'd5);
    fifo_push(16'hABCD, a);
    csr_wr(3'd0, 16'h0006);
    csr_rd(3'd3, rd);
    check("flush_level", 32'(rd), 32'd0);
    csr_rd(3'd1, rd);
    check("flush_status", 32'(rd), 32'h0001);
    fifo_push(16'h0042, a);
    csr_rd(3'd3, rd);
    check("flush_refill_level", 32'(rd), 32'd1);

    // ---------------- Low-water IRQ ----------------
    do_reset();
    csr_wr(3'd4, 16'd4);
    csr_wr(3'd2, 16'd3);
    for (int i = 0; i < 9; i++) fifo_push(16'h0100 * 16'(i), a);
    @(negedge clk);
    check("irq_low_when_disabled", 32'(irq_lowater), 32'd0);
    csr_wr(3'd0, 16'h0005);
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (irq_lowater === 1'b1) found = 1'b1;
    end
    check("irq_rose", 32'(found), 32'd1);
    csr_rd(3'd3, rd);
    check("irq_level_at_rise", 32'(rd), 32'd3);
    csr_wr(3'd0, 16'h0004);
    @(negedge clk);
    check("irq_low_after_disable", 32'(irq_lowater), 32'd0);

    check("ack_protocol_errors", 32'(ack_errs), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
